// File: rtl/pulse_pkg.sv
// Shared types for the pulse stretcher: FSM state encoding and the
// recovery target used when the state register holds an unused code.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } pulse_state_e;

    // Where an illegal state lands on the next edge.
    localparam pulse_state_e RECOVERY_STATE = IDLE;

    // Width of the gap down-counter; GAP_CYCLES is limited to 1..255.
    localparam int GAP_CNT_W = 8;

endpackage

// File: rtl/pulse_stretcher_sat_counter.sv
// Saturating up-counter: counts enabled cycles and holds at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // Stop at the top code so a long burst of events never reads as a small count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches a one-cycle trigger into a level of width_cfg cycles followed by a
// forced low gap. Define PULSE_RETRIGGER_EN to let triggers in HIGH extend the pulse.
module pulse_stretcher
    import pulse_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int GAP_CYCLES = 2,
    parameter int DROP_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    input  logic [CNT_W-1:0]  width_cfg,
    output logic              level_out,
    output logic              busy,
    output logic              done,
    output logic              drop_out,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES - 1);

    pulse_state_e         state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [GAP_CNT_W-1:0] gapCnt_q;
    logic                 level_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 drop_q;

    logic [CNT_W-1:0]     widthLoad_d;
    logic                 retrigger_d;
    logic                 dropEvent_d;

    // A zero width behaves as one cycle, so the load value never underflows.
    always_comb begin
        widthLoad_d = '0;
        if (width_cfg != '0) begin
            widthLoad_d = width_cfg - CNT_W'(1);
        end
    end

`ifdef PULSE_RETRIGGER_EN
    assign retrigger_d = pulse_in && (state_q == HIGH);
`else
    assign retrigger_d = 1'b0;
`endif

    // Anything other than IDLE at the sampling edge refuses the trigger,
    // unless it was consumed as a retrigger.
    assign dropEvent_d = pulse_in && (state_q != IDLE) && !retrigger_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gapCnt_q <= '0;
            level_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            drop_q <= dropEvent_d;
            case (state_q)
                IDLE: begin
                    if (pulse_in) begin
                        state_q <= HIGH;
                        cnt_q   <= widthLoad_d;
                        level_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                HIGH: begin
                    if (retrigger_d) begin
                        cnt_q <= widthLoad_d;
                    end else if (cnt_q == '0) begin
                        state_q  <= GAP;
                        gapCnt_q <= GAP_LOAD;
                        level_q  <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (gapCnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gapCnt_q <= gapCnt_q - GAP_CNT_W'(1);
                    end
                end
                default: begin
                    state_q  <= RECOVERY_STATE;
                    cnt_q    <= '0;
                    gapCnt_q <= '0;
                    level_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (DROP_W)
    ) u_dropCounter (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (dropEvent_d),
        .count_o (drop_cnt)
    );

    assign level_out = level_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign drop_out  = drop_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: a timeline model of the pulse windows
// checked every cycle, plus directed scenarios with hand-computed totals.
module tb_pulse_stretcher;

    localparam int CNT_W      = 8;
    localparam int GAP_CYCLES = 2;
    localparam int DROP_W     = 2;
    localparam int DROP_MAX   = (1 << DROP_W) - 1;
    localparam int NEVER      = -1000000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              pulse_in = 1'b0;
    logic [CNT_W-1:0]  width_cfg = '0;
    logic              level_out;
    logic              busy;
    logic              done;
    logic              drop_out;
    logic [DROP_W-1:0] drop_cnt;

    always #5 clk = ~clk;

    pulse_stretcher #(
        .CNT_W      (CNT_W),
        .GAP_CYCLES (GAP_CYCLES),
        .DROP_W     (DROP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .width_cfg (width_cfg),
        .level_out (level_out),
        .busy      (busy),
        .done      (done),
        .drop_out  (drop_out),
        .drop_cnt  (drop_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Model: the current pulse is described by the cycle numbers where it
    // starts, ends and where its gap ends.
    int cyc       = 0;
    int highStart = NEVER;
    int highEnd   = NEVER;
    int gapEnd    = NEVER;
    int dropAt    = NEVER;
    int dropCount = 0;
    int mc;
    int mw;
    int cn;

    int levelCount     = 0;
    int busyCount      = 0;
    int doneCount      = 0;
    int dropPulseCount = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, wanted %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Inputs held during cycle mc are seen at the edge that ends it.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            highStart = NEVER;
            highEnd   = NEVER;
            gapEnd    = NEVER;
            dropAt    = NEVER;
            dropCount = 0;
        end else begin
            mc = cyc;
            if (pulse_in) begin
                mw = (width_cfg == '0) ? 1 : int'(width_cfg);
                if (mc > gapEnd) begin
                    highStart = mc + 1;
                    highEnd   = mc + mw;
                    gapEnd    = mc + mw + GAP_CYCLES;
                end
`ifdef PULSE_RETRIGGER_EN
                else if (mc >= highStart && mc <= highEnd) begin
                    highEnd = mc + mw;
                    gapEnd  = highEnd + GAP_CYCLES;
                end
`endif
                else begin
                    dropAt = mc + 1;
                    if (dropCount < DROP_MAX) dropCount++;
                end
            end
            cyc = mc + 1;
        end
    end

    always begin
        @(posedge clk);
        #1;
        cn = cyc;
        checkOutput("level_out", int'(level_out), int'(cn >= highStart && cn <= highEnd));
        checkOutput("busy", int'(busy), int'(cn >= highStart && cn <= gapEnd));
        checkOutput("done", int'(done), int'(cn == highEnd + 1));
        checkOutput("drop_out", int'(drop_out), int'(cn == dropAt));
        checkOutput("drop_cnt", int'(drop_cnt), dropCount);
        levelCount     += int'(level_out);
        busyCount      += int'(busy);
        doneCount      += int'(done);
        dropPulseCount += int'(drop_out);
    end

    task automatic clearStats();
        levelCount     = 0;
        busyCount      = 0;
        doneCount      = 0;
        dropPulseCount = 0;
    endtask

    task automatic applyStimulus(input logic p, input int w);
        @(negedge clk);
        pulse_in  = p;
        width_cfg = w[CNT_W-1:0];
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, int'(width_cfg));
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst      = 1'b0;
        pulse_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clearStats();
    endtask

    initial begin
        $display("[TB] starting pulse_stretcher bench");

        // Power-on reset, then a quiet stretch.
        repeat (3) @(negedge clk);
        checkOutput("reset_level", int'(level_out), 0);
        checkOutput("reset_dropcnt", int'(drop_cnt), 0);
        rst = 1'b1;
        clearStats();
        idle(10);
        checkOutput("idle_level_cycles", levelCount, 0);
        checkOutput("idle_busy_cycles", busyCount, 0);

        // Basic stretch of 5 with a 2-cycle gap.
        resetDut();
        applyStimulus(1'b1, 5);
        applyStimulus(1'b0, 5);
        checkOutput("latency_level", int'(level_out), 1);
        idle(12);
        checkOutput("w5_level_cycles", levelCount, 5);
        checkOutput("w5_busy_cycles", busyCount, 7);
        checkOutput("w5_done_pulses", doneCount, 1);

        // Zero width is one cycle.
        resetDut();
        applyStimulus(1'b1, 0);
        idle(8);
        checkOutput("w0_level_cycles", levelCount, 1);
        checkOutput("w0_busy_cycles", busyCount, 3);
        checkOutput("w0_done_pulses", doneCount, 1);

        // Five extra triggers while high.
        resetDut();
        applyStimulus(1'b1, 20);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 20);
            applyStimulus(1'b1, 20);
        end
        idle(40);
`ifdef PULSE_RETRIGGER_EN
        checkOutput("burst_level_cycles", levelCount, 30);
        checkOutput("burst_drop_pulses", dropPulseCount, 0);
        checkOutput("burst_drop_cnt", int'(drop_cnt), 0);
`else
        checkOutput("burst_level_cycles", levelCount, 20);
        checkOutput("burst_drop_pulses", dropPulseCount, 5);
        checkOutput("burst_drop_cnt", int'(drop_cnt), 3);
`endif
        checkOutput("burst_done_pulses", doneCount, 1);

        // Triggers in both gap cycles are refused; the next cycle is accepted.
        resetDut();
        applyStimulus(1'b1, 3);
        repeat (3) applyStimulus(1'b0, 3);
        repeat (3) applyStimulus(1'b1, 3);
        idle(10);
        checkOutput("gap_drop_pulses", dropPulseCount, 2);
        checkOutput("gap_drop_cnt", int'(drop_cnt), 2);
        checkOutput("gap_level_cycles", levelCount, 6);
        checkOutput("gap_done_pulses", doneCount, 2);

        // Second trigger five cycles after the first.
        resetDut();
        applyStimulus(1'b1, 8);
        repeat (4) applyStimulus(1'b0, 8);
        applyStimulus(1'b1, 8);
        idle(20);
`ifdef PULSE_RETRIGGER_EN
        checkOutput("retrig_level_cycles", levelCount, 13);
        checkOutput("retrig_drop_cnt", int'(drop_cnt), 0);
`else
        checkOutput("retrig_level_cycles", levelCount, 8);
        checkOutput("retrig_drop_cnt", int'(drop_cnt), 1);
`endif
        checkOutput("retrig_done_pulses", doneCount, 1);

        // width_cfg changes while busy are ignored; max width runs in full.
        resetDut();
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 9);
        idle(10);
        checkOutput("wchange_level_cycles", levelCount, 4);
        clearStats();
        applyStimulus(1'b1, 255);
        idle(260);
        checkOutput("wmax_level_cycles", levelCount, 255);
        checkOutput("wmax_busy_cycles", busyCount, 257);

        // Reset in the middle of a long pulse, then a fresh pulse.
        resetDut();
        applyStimulus(1'b1, 100);
        idle(30);
        checkOutput("pre_reset_level_cycles", levelCount, 30);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_level", int'(level_out), 0);
        checkOutput("async_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clearStats();
        applyStimulus(1'b1, 100);
        idle(105);
        checkOutput("post_reset_level_cycles", levelCount, 100);
        checkOutput("post_reset_done_pulses", doneCount, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
